// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, STATUS bit positions and hex-printer state encoding.
package uart_pkg;
  localparam logic [31:0] UART_RX_OFFSET = 32'h0;
  localparam logic [31:0] UART_TX_OFFSET = 32'h4;
  localparam logic [31:0] UART_STATUS_OFFSET = 32'h8;
  localparam int unsigned STATUS_RX_VALID_BIT = 0;
  localparam int unsigned STATUS_TX_FULL_BIT = 1;
  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    WR_REQ,
    WR_WAIT
  } uart_hex_state_t;
endpackage

// File: rtl/uart_hex_char.sv
// uart_hex_char: maps a print position (prefix, 8 nibbles MS first, CR LF) to its ASCII byte.
module uart_hex_char (
  input  logic [3:0]  idx_i,
  input  logic [31:0] value_i,
  input  logic        upper_i,
  output logic [7:0]  char_o
);
  logic [3:0] nib;
  assign nib = 4'(value_i >> {4'd9 - idx_i, 2'b00});
  assign char_o = idx_i == 4'd0  ? 8'h30 :
                  idx_i == 4'd1  ? 8'h78 :
                  idx_i == 4'd10 ? 8'h0D :
                  idx_i == 4'd11 ? 8'h0A :
                  nib < 4'd10    ? 8'h30 + {4'h0, nib} :
                  (upper_i ? 8'h37 : 8'h57) + {4'h0, nib};
endmodule

// File: rtl/uart_hex_printer.sv
// uart_hex_printer: prints a 32-bit value as ASCII hex to the UART, polling tx_fifo_full per byte.
module uart_hex_printer
  import uart_pkg::*;
#(
  parameter logic [31:0] UartBaseAddr = 32'h8000_1000,
  parameter bit          PrefixEn     = 1'b1,
  parameter bit          NewlineEn    = 1'b1,
  parameter bit          UpperCase    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        val_valid_i,
  output logic        val_ready_o,
  input  logic [31:0] val_data_i,
  output logic        busy_o,
  output logic        dev_req_o,
  output logic [31:0] dev_addr_o,
  output logic        dev_we_o,
  output logic [3:0]  dev_be_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_rvalid_i,
  input  logic [31:0] dev_rdata_i
);
  localparam logic [3:0] FirstIdx = PrefixEn ? 4'd0 : 4'd2;
  localparam logic [3:0] LastIdx = NewlineEn ? 4'd11 : 4'd9;
  uart_hex_state_t state_q, state_d;
  logic [31:0] value_q;
  logic [3:0]  idx_q;
  logic [7:0]  char;
  logic        tx_full;
  logic        unused_rdata;
  assign tx_full = dev_rdata_i[STATUS_TX_FULL_BIT];
  assign unused_rdata = ^{dev_rdata_i[31:2], dev_rdata_i[0]};
  uart_hex_char u_char (
    .idx_i  (idx_q),
    .value_i(value_q),
    .upper_i(UpperCase),
    .char_o (char)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = val_valid_i ? POLL_REQ : IDLE;
      POLL_REQ:  state_d = POLL_WAIT;
      POLL_WAIT: state_d = !dev_rvalid_i ? POLL_WAIT : tx_full ? POLL_REQ : WR_REQ;
      WR_REQ:    state_d = WR_WAIT;
      WR_WAIT:   state_d = !dev_rvalid_i ? WR_WAIT : idx_q == LastIdx ? IDLE : POLL_REQ;
      default:   state_d = IDLE;
    endcase
  end
  // Bus address/we/wdata are loaded on entry to a request state and held until the next one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      value_q     <= '0;
      idx_q       <= '0;
      dev_addr_o  <= '0;
      dev_we_o    <= 1'b0;
      dev_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && val_valid_i) begin
        value_q <= val_data_i;
        idx_q   <= FirstIdx;
      end
      if (state_q == WR_WAIT && dev_rvalid_i && idx_q != LastIdx) idx_q <= idx_q + 4'd1;
      if (state_d == POLL_REQ) begin
        dev_addr_o <= UartBaseAddr + UART_STATUS_OFFSET;
        dev_we_o   <= 1'b0;
      end
      if (state_d == WR_REQ) begin
        dev_addr_o  <= UartBaseAddr + UART_TX_OFFSET;
        dev_we_o    <= 1'b1;
        dev_wdata_o <= {24'h0, char};
      end
    end
  end
  assign val_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign dev_req_o   = state_q == POLL_REQ || state_q == WR_REQ;
  assign dev_be_o    = 4'b0001;
endmodule

// File: tb/tb_uart_hex_printer.sv
// tb_uart_hex_printer: two printer configurations driven against a scriptable UART model.
module tb_uart_hex_printer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        valid[2], ready[2], busy[2], req[2], we[2], rvalid[2];
  logic [31:0] data[2], addr[2], wdata[2], rdata[2];
  logic [3:0]  be[2];
  uart_hex_printer u_a (
    .clk_i(clk), .rst_i(rst), .val_valid_i(valid[0]), .val_ready_o(ready[0]),
    .val_data_i(data[0]), .busy_o(busy[0]), .dev_req_o(req[0]), .dev_addr_o(addr[0]),
    .dev_we_o(we[0]), .dev_be_o(be[0]), .dev_wdata_o(wdata[0]),
    .dev_rvalid_i(rvalid[0]), .dev_rdata_i(rdata[0])
  );
  uart_hex_printer #(.PrefixEn(1'b0), .NewlineEn(1'b0), .UpperCase(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .val_valid_i(valid[1]), .val_ready_o(ready[1]),
    .val_data_i(data[1]), .busy_o(busy[1]), .dev_req_o(req[1]), .dev_addr_o(addr[1]),
    .dev_we_o(we[1]), .dev_be_o(be[1]), .dev_wdata_o(wdata[1]),
    .dev_rvalid_i(rvalid[1]), .dev_rdata_i(rdata[1])
  );
  int checks = 0, failures = 0;
  int wr_cnt[2], rd_cnt[2];
  int stall_at = -1, stall_total = 0, stall_given = 0;
  logic [7:0] wr_log[2][64];
  logic prev_req[2], last_full[2];
  logic stall_now;
  assign stall_now = req[0] && !we[0] && wr_cnt[0] == stall_at && stall_given < stall_total;
  // UART model: response one cycle after each request; STATUS reports full only when scripted.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rvalid[d] <= req[d] && !rst;
      rdata[d]  <= (d == 0 && stall_now) ? 32'h0000_0002 : 32'hFFFF_FFFD;
    end
    if (stall_now) stall_given <= stall_given + 1;
  end
  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic mon;
    for (int d = 0; d < 2; d++) begin
      if (req[d]) begin
        checks++;
        if (prev_req[d] || be[d] !== 4'b0001 || wdata[d][31:8] !== 24'h0 ||
            addr[d] !== (we[d] ? 32'h8000_1004 : 32'h8000_1008) || (we[d] && last_full[d])) begin
          failures++;
          $display("FAIL access dut%0d prev_req=%b be=%b addr=%h we=%b wdata=%h after_full=%b",
                   d, prev_req[d], be[d], addr[d], we[d], wdata[d], last_full[d]);
        end
        if (we[d]) begin
          wr_log[d][wr_cnt[d] % 64] = wdata[d][7:0];
          wr_cnt[d]++;
        end else rd_cnt[d]++;
      end
      if (rvalid[d] && !we[d]) last_full[d] = rdata[d][1];
      prev_req[d] = req[d];
    end
  endtask
  task automatic tick;
    @(negedge clk);
    mon();
  endtask
  function automatic logic [95:0] got_bytes(input int d, input int start);
    logic [95:0] g = '0;
    for (int i = start; i < wr_cnt[d]; i++) g = {g[87:0], wr_log[d][i % 64]};
    return g;
  endfunction
  task automatic run(input string name, input int d, input logic [31:0] v, input logic hold,
                     input logic [31:0] v2, input logic [95:0] exp, input int exp_busy);
    int n = 0, busy_n = 0, start;
    while (!ready[d] && n < 300) begin
      tick();
      n++;
    end
    start = wr_cnt[d];
    valid[d] = 1'b1;
    data[d] = v;
    tick();
    if (hold) data[d] = v2;
    else valid[d] = 1'b0;
    while (!ready[d] && busy_n < 300) begin
      busy_n++;
      tick();
    end
    chk({name, " bytes"}, got_bytes(d, start), exp);
    chk({name, " count"}, 96'(wr_cnt[d] - start), d == 0 ? 96'd12 : 96'd8);
    chk({name, " busy"}, 96'(busy_n), 96'(exp_busy));
  endtask
  typedef struct {
    string       name;
    int          d;
    logic [31:0] v;
    logic [95:0] exp;
    int          busy;
  } vec_t;
  vec_t vecs[7];
  int b, start, rd0;
  initial begin
    vecs[0] = '{"deadbeef", 0, 32'hDEAD_BEEF, 96'h3078_4445_4144_4245_4546_0D0A, 48};
    vecs[1] = '{"zero", 0, 32'h0000_0000, 96'h3078_3030_3030_3030_3030_0D0A, 48};
    vecs[2] = '{"ones", 0, 32'hFFFF_FFFF, 96'h3078_4646_4646_4646_4646_0D0A, 48};
    vecs[3] = '{"seq", 0, 32'h1234_5678, 96'h3078_3132_3334_3536_3738_0D0A, 48};
    vecs[4] = '{"nine_a", 0, 32'h9ABC_0A5F, 96'h3078_3941_4243_3041_3546_0D0A, 48};
    vecs[5] = '{"lc_af", 1, 32'h0000_00AF, 96'h3030_3030_3030_6166, 32};
    vecs[6] = '{"lc_fedc", 1, 32'hFEDC_BA98, 96'h6665_6463_6261_3938, 32};
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0;
      data[d] = '0;
      wr_cnt[d] = 0;
      rd_cnt[d] = 0;
      prev_req[d] = 1'b0;
      last_full[d] = 1'b0;
    end
    tick();
    tick();
    chk("reset", {ready[0], busy[0], req[0], we[0], addr[0], wdata[0]}, {4'b1000, 64'h0});
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) run(vecs[i].name, vecs[i].d, vecs[i].v, 1'b0, 32'h0, vecs[i].exp, vecs[i].busy);
    // Three full STATUS polls before the fifth byte.
    stall_at = wr_cnt[0] + 4;
    stall_total = 3;
    rd0 = rd_cnt[0];
    run("stall", 0, 32'hCAFE_F00D, 1'b0, 32'h0, 96'h3078_4341_4645_4630_3044_0D0A, 54);
    chk("stall reads", 96'(rd_cnt[0] - rd0), 96'd15);
    chk("stall given", 96'(stall_given), 96'd3);
    // valid held with changing data while busy: second value waits for IDLE.
    run("hold first", 0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 96'h3078_4445_4144_4245_4546_0D0A, 48);
    run("hold second", 0, 32'h1234_5678, 1'b0, 32'h0, 96'h3078_3132_3334_3536_3738_0D0A, 48);
    // Reset while waiting for the write response of the fifth byte.
    start = wr_cnt[0];
    valid[0] = 1'b1;
    data[0] = 32'hA5A5_A5A5;
    tick();
    valid[0] = 1'b0;
    repeat (19) tick();
    chk("pre-reset writes", 96'(wr_cnt[0] - start), 96'd5);
    rst = 1'b1;
    tick();
    chk("mid reset", {req[0], ready[0], busy[0]}, 96'b010);
    rst = 1'b0;
    tick();
    chk("after reset", {req[0], ready[0], busy[0]}, 96'b010);
    run("post reset", 0, 32'h0BAD_F00D, 1'b0, 32'h0, 96'h3078_3042_4144_4630_3044_0D0A, 48);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
